// File: rtl/matrix_checker_rt.sv
// AXI4-Stream result sink: checks one fixed-size frame against a constant, with a watchdog and a saturating error count.
// Optional TLAST framing check enabled by defining MATRIX_CHECKER_TLAST_CHECK_EN.
module matrix_checker_rt #(
    parameter logic [19:0] Stop_Counter_Value = 20'd20000,
    parameter int          Num_Words          = 216,
    parameter logic [31:0] Expected_Value     = 32'd12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        output_r_TVALID_0,
    input  logic        output_r_TLAST_0,
    input  logic [31:0] output_r_TDATA_0,
    output logic        output_r_TREADY_0,
    output logic [3:0]  Error_Counter
);

    // state   | meaning
    // IDLE    | after reset, ready drops; leaves on first edge out of reset
    // RECEIVE | TREADY high, beats checked, watchdog running
    // DONE    | frame finished or timed out; holds until reset
    typedef enum logic [1:0] {IDLE, RECEIVE, DONE} state_t;

    localparam logic [7:0]  LAST_IDX  = 8'(Num_Words - 1);
    localparam logic [19:0] WDOG_LAST = Stop_Counter_Value - 20'd1;

    state_t      state_q, state_d;
    logic [7:0]  word_cnt_q, word_cnt_d;
    logic [19:0] wdog_q, wdog_d;
    logic [3:0]  err_q, err_d;
    logic        tready_q, tready_d;

    logic       beat;
    logic       last_word;
    logic       data_err;
    logic       tlast_err;
    logic       timeout_err;
    logic [1:0] err_add;
    logic [4:0] err_sum;

`ifndef MATRIX_CHECKER_TLAST_CHECK_EN
    logic unused_tlast;
    assign unused_tlast = output_r_TLAST_0;
`endif

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        wdog_d      = wdog_q;
        err_d       = err_q;
        beat        = (state_q == RECEIVE) && output_r_TVALID_0;
        last_word   = (word_cnt_q == LAST_IDX);
        data_err    = beat && (output_r_TDATA_0 != Expected_Value);
`ifdef MATRIX_CHECKER_TLAST_CHECK_EN
        tlast_err   = beat && (output_r_TLAST_0 != last_word);
`else
        tlast_err   = 1'b0;
`endif
        // the final beat wins over a watchdog expiry on the same edge
        timeout_err = (state_q == RECEIVE) && (wdog_q == WDOG_LAST) && !(beat && last_word);
        err_add     = {1'b0, data_err} + {1'b0, tlast_err} + {1'b0, timeout_err};
        err_sum     = {1'b0, err_q} + {3'b000, err_add};

        case (state_q)
            IDLE: begin
                state_d = RECEIVE;
            end
            RECEIVE: begin
                wdog_d = wdog_q + 20'd1;
                err_d  = (err_sum > 5'd15) ? 4'd15 : err_sum[3:0];
                if (beat) begin
                    word_cnt_d = word_cnt_q + 8'd1;
                end
                if ((beat && last_word) || timeout_err) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = DONE;
            end
        endcase

        tready_d = (state_d == RECEIVE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            word_cnt_q <= 8'd0;
            wdog_q     <= 20'd0;
            err_q      <= 4'd0;
            tready_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            wdog_q     <= wdog_d;
            err_q      <= err_d;
            tready_q   <= tready_d;
        end
    end

    assign output_r_TREADY_0 = tready_q;
    assign Error_Counter     = err_q;

endmodule

// File: tb/tb_matrix_checker_rt.sv
// Testbench for matrix_checker_rt: frame-level reference model checked every cycle, plus literal per-frame expectations.
module tb_matrix_checker_rt;

    localparam int N    = 216;
    localparam int STOP = 20000;
    localparam int EXPV = 12;
`ifdef MATRIX_CHECKER_TLAST_CHECK_EN
    localparam int TL = 1;
`else
    localparam int TL = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic [31:0] tdata = 32'd0;
    logic        tready;
    logic [3:0]  err;

    int checks = 0;
    int passes = 0;

    matrix_checker_rt dut (
        .clk               (clk),
        .reset             (reset),
        .output_r_TVALID_0 (tvalid),
        .output_r_TLAST_0  (tlast),
        .output_r_TDATA_0  (tdata),
        .output_r_TREADY_0 (tready),
        .Error_Counter     (err)
    );

    always #5 clk = ~clk;

    // Frame-level model: phase 0 waiting, 1 receiving, 2 finished.
    int m_phase = 0;
    int m_words = 0;
    int m_cycles = 0;
    int m_err = 0;
    bit m_live = 1'b0;

    always @(posedge clk) begin
        int add;
        bit fin;
        if (!reset) begin
            m_phase = 0; m_words = 0; m_cycles = 0; m_err = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            add = 0;
            fin = 1'b0;
            if (tvalid) begin
                m_words++;
                if (tdata != EXPV) add++;
                if (TL == 1 && ((m_words == N) != tlast)) add++;
                if (m_words == N) fin = 1'b1;
            end
            m_cycles++;
            if (!fin && m_cycles == STOP) begin
                add++;
                fin = 1'b1;
            end
            m_err = (m_err + add > 15) ? 15 : m_err + add;
            if (fin) m_phase = 2;
        end
        m_live = 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            check("ready_vs_model", int'(tready), (m_phase == 1) ? 1 : 0);
            check("err_vs_model", int'(err), m_err);
        end
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = 32'd0;
        repeat (n) @(negedge clk);
        check("ready_in_reset", int'(tready), 0);
        check("err_in_reset", int'(err), 0);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_release", int'(tready), 1);
    endtask

    // mode 0 clean, 1 no TLAST, 2 words 5/100 bad, 3 all zero, 4 bubbles + early TLAST
    task automatic send_frame(input int mode, input int nwords);
        for (int w = 1; w <= nwords; w++) begin
            if (mode == 4 && (w % 3) == 0) begin
                tvalid = 1'b0;
                @(negedge clk);
            end
            tvalid = 1'b1;
            tdata  = (mode == 3) ? 32'd0 : ((mode == 2 && (w == 5 || w == 100)) ? 32'd13 : 32'd12);
            tlast  = (mode != 1 && w == N) || (mode == 4 && w == 10);
            @(negedge clk);
        end
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    initial begin
        int k;
        do_reset(50);
        send_frame(0, N);
        @(negedge clk);
        check("clean_ready_low", int'(tready), 0);
        check("clean_err", int'(err), 0);

        tvalid = 1'b1; tdata = 32'd0; tlast = 1'b1;
        repeat (5) @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0;
        check("done_ignores_valid", int'(err), 0);

        do_reset(3);
        send_frame(1, N);
        repeat (2) @(negedge clk);
        check("no_tlast_err", int'(err), TL);

        do_reset(3);
        send_frame(2, N);
        repeat (2) @(negedge clk);
        check("two_bad_words", int'(err), 2);

        do_reset(3);
        send_frame(3, N);
        repeat (2) @(negedge clk);
        check("all_zero_saturate", int'(err), 15);

        do_reset(3);
        send_frame(4, N);
        repeat (2) @(negedge clk);
        check("bubbles_early_tlast", int'(err), TL);
        check("bubbles_ready_low", int'(tready), 0);

        do_reset(3);
        send_frame(3, 50);
        check("midframe_err_before_reset", int'(err), 15);
        do_reset(4);
        send_frame(0, N);
        repeat (2) @(negedge clk);
        check("after_abort_clean", int'(err), 0);

        do_reset(3);
        send_frame(0, 100);
        k = 0;
        while (tready === 1'b1 && k < STOP + 100) begin
            @(negedge clk);
            k++;
        end
        check("timeout_reached", (k < STOP + 100) ? 1 : 0, 1);
        check("timeout_err", int'(err), 1);
        check("timeout_ready_low", int'(tready), 0);
        repeat (3) @(negedge clk);
        check("timeout_err_holds", int'(err), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
